// File: rtl/game_tick_gen_pkg.sv
// game_tick_pkg: shared defaults and helpers for the game tick generator.
// Contents: default 640x480 last-pixel addresses, default widths, the
// per-channel state type and eff_period() (maps a period of 0 to 1).
package game_tick_pkg;

    localparam int unsigned DEF_X_W      = 10;
    localparam int unsigned DEF_Y_W      = 10;
    localparam int unsigned DEF_LAST_X   = 639;
    localparam int unsigned DEF_LAST_Y   = 479;
    localparam int unsigned DEF_NUM_CH   = 2;
    localparam int unsigned DEF_PERIOD_W = 4;
    localparam int unsigned DEF_CNT_W    = 8;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_COUNT = 1'b1
    } ch_state_t;

    // Frames per tick; a programmed 0 behaves like 1.
    function automatic int unsigned eff_period(input int unsigned period);
        return (period == 0) ? 1 : period;
    endfunction

endpackage

// File: rtl/game_tick_gen_if.sv
// game_tick_gen_if: scan coordinates, per-channel configuration and tick
// outputs of the game tick generator.
//   master: drives x_in, y_in, period_in, enable_in (and pause_in), reads outputs
//   slave : the generator itself
// Optional macro GAME_TICK_PAUSE_EN adds pause_in.
interface game_tick_gen_if
    import game_tick_pkg::*;
#(
    parameter int unsigned X_W      = DEF_X_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) ();

    logic [X_W-1:0]             x_in;
    logic [Y_W-1:0]             y_in;
    logic [NUM_CH*PERIOD_W-1:0] period_in;
    logic [NUM_CH-1:0]          enable_in;
`ifdef GAME_TICK_PAUSE_EN
    logic                       pause_in;
`endif
    logic                       frame_end_out;
    logic [NUM_CH-1:0]          tick_out;
    logic [NUM_CH*CNT_W-1:0]    tick_cnt_out;

    modport master (
`ifdef GAME_TICK_PAUSE_EN
        output pause_in,
`endif
        output x_in, y_in, period_in, enable_in,
        input  frame_end_out, tick_out, tick_cnt_out
    );

    modport slave (
`ifdef GAME_TICK_PAUSE_EN
        input  pause_in,
`endif
        input  x_in, y_in, period_in, enable_in,
        output frame_end_out, tick_out, tick_cnt_out
    );

endinterface

// File: rtl/game_tick_gen_channel.sv
// game_tick_channel: one tick channel. Counts frame ends and emits a
// one-cycle tick every eff_period(i_period) frame ends, with a wrap-around
// tick counter.
//   in_clk, reset : clock, asynchronous active-high reset
//   i_frame_end   : registered one-cycle frame-end pulse
//   i_period      : frames per tick (0 treated as 1)
//   i_enable      : channel enable; disabled clears the frame count
//   i_pause       : freeze frame count and tick count
//   o_tick        : one-cycle tick
//   o_tick_cnt    : number of ticks issued, modulo 2^CNT_W
module game_tick_channel
    import game_tick_pkg::*;
#(
    parameter int unsigned PERIOD_W = DEF_PERIOD_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                in_clk,
    input  logic                reset,
    input  logic                i_frame_end,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_enable,
    input  logic                i_pause,
    output logic                o_tick,
    output logic [CNT_W-1:0]    o_tick_cnt
);

    ch_state_t           w_state;
    logic [PERIOD_W-1:0] w_last_fcnt;
    logic [PERIOD_W-1:0] r_fcnt;
    logic                r_tick;
    logic [CNT_W-1:0]    r_tick_cnt;

    always_comb begin
        w_state     = (i_enable && !i_pause) ? CH_COUNT : CH_IDLE;
        w_last_fcnt = PERIOD_W'(eff_period(32'(i_period)) - 1);
    end

    // '>=' so that lowering the period below the current count ticks on
    // the very next frame end instead of running around the counter.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_fcnt     <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_tick <= 1'b0;
            case (w_state)
                CH_COUNT: begin
                    if (i_frame_end) begin
                        if (r_fcnt >= w_last_fcnt) begin
                            r_fcnt     <= '0;
                            r_tick     <= 1'b1;
                            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
                        end else begin
                            r_fcnt <= r_fcnt + PERIOD_W'(1);
                        end
                    end
                end
                CH_IDLE: begin
                    // Pause freezes the count; only a disable clears it.
                    if (!i_enable) begin
                        r_fcnt <= '0;
                    end
                end
                default: r_fcnt <= '0;
            endcase
        end
    end

    assign o_tick     = r_tick;
    assign o_tick_cnt = r_tick_cnt;

endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel game tick generator. Detects the end of each
// displayed frame from the scan coordinates and drives NUM_CH independently
// programmable tick channels.
//   in_clk : clock
//   reset  : asynchronous, active-high reset
//   bus    : game_tick_gen_if.slave (coordinates, periods, enables, outputs)
// Optional macro GAME_TICK_PAUSE_EN: adds pause_in, which freezes all
// channels while frame_end_out keeps pulsing.
module game_tick_gen
    import game_tick_pkg::*;
#(
    parameter int unsigned X_W      = DEF_X_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned LAST_X   = DEF_LAST_X,
    parameter int unsigned LAST_Y   = DEF_LAST_Y,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic          in_clk,
    input  logic          reset,
    game_tick_gen_if.slave bus
);

    logic                    w_match;
    logic                    w_pause;
    logic                    r_match;
    logic                    r_frame_end;
    logic [NUM_CH-1:0]       w_tick;
    logic [NUM_CH*CNT_W-1:0] w_tick_cnt;

    always_comb begin
        w_match = (bus.x_in == X_W'(LAST_X)) && (bus.y_in == Y_W'(LAST_Y));
`ifdef GAME_TICK_PAUSE_EN
        w_pause = bus.pause_in;
`else
        w_pause = 1'b0;
`endif
    end

    // r_match resets to 1 so releasing reset on the last pixel does not
    // report a frame end for a frame that was never fully scanned.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_match     <= 1'b1;
            r_frame_end <= 1'b0;
        end else begin
            r_match     <= w_match;
            r_frame_end <= w_match & ~r_match;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        game_tick_channel #(
            .PERIOD_W (PERIOD_W),
            .CNT_W    (CNT_W)
        ) u_ch (
            .in_clk      (in_clk),
            .reset       (reset),
            .i_frame_end (r_frame_end),
            .i_period    (bus.period_in[gi*PERIOD_W +: PERIOD_W]),
            .i_enable    (bus.enable_in[gi]),
            .i_pause     (w_pause),
            .o_tick      (w_tick[gi]),
            .o_tick_cnt  (w_tick_cnt[gi*CNT_W +: CNT_W])
        );
    end

    assign bus.frame_end_out = r_frame_end;
    assign bus.tick_out      = w_tick;
    assign bus.tick_cnt_out  = w_tick_cnt;

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: self-checking bench for game_tick_gen. A frame-level
// reference model (frames seen per channel, total ticks) predicts every
// output each cycle; directed phases cover the listed scenarios and a
// randomized phase follows. Define GAME_TICK_PAUSE_EN to include pause.
module tb_game_tick_gen;
    import game_tick_pkg::*;

    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned LAST_X   = 639;
    localparam int unsigned LAST_Y   = 479;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned PERIOD_W = 4;
    localparam int unsigned CNT_W    = 8;

    logic in_clk = 1'b0;
    logic reset  = 1'b1;

    game_tick_gen_if #(
        .X_W(X_W), .Y_W(Y_W), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
    ) bus ();

    game_tick_gen #(
        .X_W(X_W), .Y_W(Y_W), .LAST_X(LAST_X), .LAST_Y(LAST_Y),
        .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
    ) dut (
        .in_clk (in_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus state
    int xv, yv;
    int per [NUM_CH];
    bit en  [NUM_CH];
    bit pz;

    // reference model
    bit          m_match_r;
    bit          m_fe;
    bit          m_tick   [NUM_CH];
    int          m_frames [NUM_CH];
    int unsigned m_ticks  [NUM_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_cnt(input int ch);
        return 64'(bus.tick_cnt_out[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [63:0] mod_cnt(input int unsigned v);
        return 64'(v % (1 << CNT_W));
    endfunction

    task automatic drive();
        bus.x_in = X_W'(xv);
        bus.y_in = Y_W'(yv);
        for (int i = 0; i < NUM_CH; i++) begin
            bus.period_in[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(per[i]);
            bus.enable_in[i] = en[i];
        end
`ifdef GAME_TICK_PAUSE_EN
        bus.pause_in = pz;
`endif
    endtask

    task automatic model_reset();
        m_match_r = 1'b1;
        m_fe      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i]   = 1'b0;
            m_frames[i] = 0;
            m_ticks[i]  = 0;
        end
    endtask

    task automatic compare(input string ctx);
        check({ctx, "_frame_end"}, 64'(bus.frame_end_out), 64'(m_fe));
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("%s_tick%0d", ctx, i), 64'(bus.tick_out[i]), 64'(m_tick[i]));
            check($sformatf("%s_cnt%0d", ctx, i), dut_cnt(i), mod_cnt(m_ticks[i]));
        end
    endtask

    // One clock: apply inputs, advance model by one edge, compare.
    task automatic step();
        bit match;
        int eff;
        drive();
        @(posedge in_clk);
        #1;
        match = (xv == int'(LAST_X)) && (yv == int'(LAST_Y));
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 1'b0;
            if (en[i] && !pz) begin
                if (m_fe) begin
                    eff = (per[i] == 0) ? 1 : per[i];
                    m_frames[i]++;
                    if (m_frames[i] >= eff) begin
                        m_frames[i] = 0;
                        m_tick[i]   = 1'b1;
                        m_ticks[i]++;
                    end
                end
            end else if (!en[i]) begin
                m_frames[i] = 0;
            end
        end
        m_fe      = match && !m_match_r;
        m_match_r = match;
        compare("cyc");
    endtask

    task automatic set_idle_xy();
        xv = $urandom_range(0, LAST_X);
        yv = $urandom_range(0, LAST_Y - 1);
    endtask

    task automatic frame(input int dwell, input int tail);
        repeat (dwell) begin
            xv = LAST_X;
            yv = LAST_Y;
            step();
        end
        repeat (tail) begin
            set_idle_xy();
            step();
        end
    endtask

    // Called #1 after an edge: asserts reset asynchronously, holds it one
    // edge, then releases.
    task automatic async_reset(input bit at_last);
        if (at_last) begin
            xv = LAST_X;
            yv = LAST_Y;
        end
        drive();
        reset = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        @(posedge in_clk);
        #1;
        compare("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned snap;
        for (int i = 0; i < NUM_CH; i++) begin
            per[i] = 1;
            en[i]  = 1'b0;
        end
        pz = 1'b0;
        set_idle_xy();
        drive();
        model_reset();

        // reset state
        repeat (2) @(posedge in_clk);
        #1;
        compare("reset");
        reset = 1'b0;
        set_idle_xy();
        step();

        // frame detection latency with 3-cycle dwell
        xv = LAST_X; yv = LAST_Y;
        step();
        check("fe_latency", 64'(bus.frame_end_out), 64'd1);
        step();
        check("fe_dwell1", 64'(bus.frame_end_out), 64'd0);
        step();
        check("fe_dwell2", 64'(bus.frame_end_out), 64'd0);
        set_idle_xy();
        step();
        step();

        // independent channels: ch0=5, ch1=1 for 10 frames
        per[0] = 5; per[1] = 1; en[0] = 1'b1; en[1] = 1'b1;
        for (int f = 0; f < 10; f++) frame(3, 2);
        check("ch0_cnt_10f", dut_cnt(0), 64'd2);
        check("ch1_cnt_10f", dut_cnt(1), 64'd10);

        // period 0 on ch1 ticks every frame
        per[1] = 0;
        snap = m_ticks[1];
        for (int f = 0; f < 3; f++) frame(1, 2);
        check("per0_ticks", dut_cnt(1), mod_cnt(snap + 3));

        // mid-count reduction: period 8, 6 frames, then period 3
        en[0] = 1'b0; step();
        en[0] = 1'b1; per[0] = 8;
        snap = m_ticks[0];
        for (int f = 0; f < 6; f++) frame(2, 2);
        check("p8_no_tick", dut_cnt(0), mod_cnt(snap));
        per[0] = 3;
        frame(1, 2);
        check("reduce_tick", dut_cnt(0), mod_cnt(snap + 1));
        for (int f = 0; f < 3; f++) frame(1, 2);
        check("reduce_then3", dut_cnt(0), mod_cnt(snap + 2));

        // disable mid-count, then re-enable with period 4
        frame(1, 2);
        en[0] = 1'b0;
        snap = m_ticks[0];
        for (int f = 0; f < 3; f++) frame(1, 2);
        check("dis_hold", dut_cnt(0), mod_cnt(snap));
        en[0] = 1'b1; per[0] = 4;
        for (int f = 0; f < 3; f++) frame(1, 2);
        check("reen_3f", dut_cnt(0), mod_cnt(snap));
        frame(1, 2);
        check("reen_4f", dut_cnt(0), mod_cnt(snap + 1));

        // tick counter wrap on ch1
        en[0] = 1'b0; per[1] = 1;
        snap = m_ticks[1];
        for (int f = 0; f < 260; f++) frame(1, 1);
        set_idle_xy(); step();
        check("wrap", dut_cnt(1), mod_cnt(snap + 260));

        // reset asserted and released on the last pixel
        async_reset(1'b1);
        repeat (3) step();
        check("rst_last_no_fe", 64'(bus.frame_end_out), 64'd0);
        set_idle_xy(); step();
        frame(1, 2);
        check("rst_next_frame", dut_cnt(1), 64'd1);

        // reset mid-count
        en[0] = 1'b1; en[1] = 1'b1; per[0] = 3; per[1] = 2;
        for (int f = 0; f < 4; f++) frame(1, 2);
        async_reset(1'b0);
        check("rst_mid_cnt0", dut_cnt(0), 64'd0);
        check("rst_mid_cnt1", dut_cnt(1), 64'd0);
        set_idle_xy(); step();

`ifdef GAME_TICK_PAUSE_EN
        // pause after 2 frames for 5 frames at period 3
        en[0] = 1'b1; en[1] = 1'b0; per[0] = 3;
        snap = m_ticks[0];
        for (int f = 0; f < 2; f++) frame(1, 2);
        pz = 1'b1;
        for (int f = 0; f < 5; f++) begin
            xv = LAST_X; yv = LAST_Y;
            step();
            check("pause_fe", 64'(bus.frame_end_out), 64'd1);
            set_idle_xy();
            step(); step();
            check("pause_tick", 64'(bus.tick_out[0]), 64'd0);
        end
        check("pause_hold", dut_cnt(0), mod_cnt(snap));
        pz = 1'b0;
        frame(1, 2);
        check("pause_resume", dut_cnt(0), mod_cnt(snap + 1));
`endif

        // randomized phase
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    per[i] = $urandom_range(0, (1 << PERIOD_W) - 1);
                    en[i]  = ($urandom_range(0, 4) != 0);
                end
            end
`ifdef GAME_TICK_PAUSE_EN
            pz = ($urandom_range(0, 5) == 0);
`endif
            frame($urandom_range(1, 3), $urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                per[0] = $urandom_range(0, (1 << PERIOD_W) - 1);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
